// File: rtl/filtro_pkg.sv
// Shared widths, FSM state type, coefficient indices and saturation limits
// for the time-multiplexed direct-form-II biquad.
package filtro_pkg;

    localparam int W    = 25;
    localparam int FRAC = 13;

    typedef enum logic [2:0] {
        IDLE,
        FB1,
        FB2,
        FF0,
        FF1,
        FF2
    } state_t;

    localparam logic [2:0] IDX_B0 = 3'd0;
    localparam logic [2:0] IDX_B1 = 3'd1;
    localparam logic [2:0] IDX_B2 = 3'd2;
    localparam logic [2:0] IDX_A1 = 3'd3;
    localparam logic [2:0] IDX_A2 = 3'd4;

    localparam logic signed [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

endpackage

// File: rtl/mult_q.sv
// Shared fixed-point multiply-accumulate step: addend + (coef*data >>> FRAC),
// clamped to the signed W-bit range.
module mult_q #(
    parameter int W    = filtro_pkg::W,
    parameter int FRAC = filtro_pkg::FRAC
) (
    input  logic signed [W-1:0] coef,
    input  logic signed [W-1:0] data,
    input  logic signed [W-1:0] addend,
    output logic signed [W-1:0] result
);

    localparam int PW = 2 * W;
    localparam logic signed [PW:0] HI = $signed({{(PW-W+2){1'b0}}, {(W-1){1'b1}}});
    localparam logic signed [PW:0] LO = $signed({{(PW-W+2){1'b1}}, {(W-1){1'b0}}});

    logic signed [PW-1:0] product;
    logic signed [PW:0]   sum;

    // The sum is one bit wider than the product so it can never wrap before the clamp.
    assign product = PW'(coef) * PW'(data);
    assign sum     = (PW+1)'(product >>> FRAC) + (PW+1)'(addend);

    always_comb begin
        if (sum > HI) begin
            result = HI[W-1:0];
        end else if (sum < LO) begin
            result = LO[W-1:0];
        end else begin
            result = sum[W-1:0];
        end
    end

endmodule

// File: rtl/secuenciador_biquad.sv
// Direct-form-II biquad sequencer: a single shared multiplier walks the five
// products of each sample through a six-state FSM, one product per cycle.
module secuenciador_biquad
    import filtro_pkg::*;
#(
    parameter int W    = filtro_pkg::W,
    parameter int FRAC = filtro_pkg::FRAC
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic                Enable,
    input  logic                start,
    input  logic signed [W-1:0] u,
    input  logic                coef_we,
    input  logic [2:0]          coef_addr,
    input  logic signed [W-1:0] coef_data,
    input  logic                clr_hist,
    output logic                busy,
    output logic                done,
    output logic signed [W-1:0] y,
    output logic                overrun
);

    localparam logic signed [W-1:0] UNITY = W'(2 ** FRAC);

    state_t state;
    logic signed [W-1:0] acc, w, w1, w2;
    logic signed [W-1:0] b0, b1, b2, a1, a2;
    logic signed [W-1:0] mul_coef, mul_data, mul_add, mul_res;
    logic done_q, overrun_q;

    always_comb begin
        mul_coef = '0;
        mul_data = '0;
        mul_add  = acc;
        case (state)
            FB1: begin mul_coef = a1; mul_data = w1; end
            FB2: begin mul_coef = a2; mul_data = w2; end
            FF0: begin mul_coef = b0; mul_data = w; mul_add = '0; end
            FF1: begin mul_coef = b1; mul_data = w1; end
            FF2: begin mul_coef = b2; mul_data = w2; end
            default: ;
        endcase
    end

    mult_q #(.W(W), .FRAC(FRAC)) u_mult (
        .coef   (mul_coef),
        .data   (mul_data),
        .addend (mul_add),
        .result (mul_res)
    );

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            acc       <= '0;
            w         <= '0;
            w1        <= '0;
            w2        <= '0;
            y         <= '0;
            b0        <= UNITY;
            b1        <= '0;
            b2        <= '0;
            a1        <= '0;
            a2        <= '0;
        end else if (Enable) begin
            done_q    <= 1'b0;
            overrun_q <= start && (state != IDLE);
            case (state)
                IDLE: begin
                    // Coefficient write and history clear land on the same edge that
                    // accepts start, so the new sample already sees both.
                    if (coef_we) begin
                        case (coef_addr)
                            IDX_B0:  b0 <= coef_data;
                            IDX_B1:  b1 <= coef_data;
                            IDX_B2:  b2 <= coef_data;
                            IDX_A1:  a1 <= coef_data;
                            IDX_A2:  a2 <= coef_data;
                            default: ;
                        endcase
                    end
                    if (clr_hist) begin
                        w1 <= '0;
                        w2 <= '0;
                    end
                    if (start) begin
                        acc   <= u;
                        state <= FB1;
                        busy  <= 1'b1;
                    end
                end
                FB1: begin
                    acc   <= mul_res;
                    state <= FB2;
                end
                FB2: begin
                    acc   <= mul_res;
                    w     <= mul_res;
                    state <= FF0;
                end
                FF0: begin
                    acc   <= mul_res;
                    state <= FF1;
                end
                FF1: begin
                    acc   <= mul_res;
                    state <= FF2;
                end
                FF2: begin
                    acc    <= mul_res;
                    y      <= mul_res;
                    w1     <= w;
                    w2     <= w1;
                    done_q <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign done    = done_q & Enable;
    assign overrun = overrun_q & Enable;

endmodule

// File: doc/secuenciador_biquad.md
SECUENCIADOR_BIQUAD -- requirements
Module: secuenciador_biquad

Interface
REQ-001 SHALL have parameter W, default 25, sample/coefficient word width (signed two's complement).
REQ-002 SHALL have parameter FRAC, default 13, number of fractional bits of every coefficient (1.0 = 8192).
REQ-003 SHALL have port CLK, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port Enable, input, 1, global advance; when 0 all registers hold.
REQ-006 SHALL have port start, input, 1, sample request; u valid in the same cycle.
REQ-007 SHALL have port u, input, W signed, input sample.
REQ-008 SHALL have port coef_we, input, 1, coefficient write strobe.
REQ-009 SHALL have port coef_addr, input, 3, coefficient index: 0=b0, 1=b1, 2=b2, 3=a1, 4=a2; 5-7 reserved.
REQ-010 SHALL have port coef_data, input, W signed, coefficient value.
REQ-011 SHALL have port clr_hist, input, 1, clears w1/w2 history.
REQ-012 SHALL have port busy, output, 1, computation in progress.
REQ-013 SHALL have port done, output, 1, one-cycle pulse; y updated.
REQ-014 SHALL have port y, output, W signed, filtered sample.
REQ-015 SHALL have port overrun, output, 1, one-cycle pulse; start rejected.

Function
REQ-016 SHALL compute direct-form-II biquad: w = u + a1*w1 + a2*w2; y = b0*w + b1*w1 + b2*w2; then w2<=w1, w1<=w.
REQ-017 SHALL use exactly one shared signed W x W multiplier, time-multiplexed by the FSM, one product per cycle.
REQ-018 SHALL use FSM states IDLE, FB1, FB2, FF0, FF1, FF2; order IDLE->FB1->FB2->FF0->FF1->FF2->IDLE.
REQ-019 IDLE->FB1 SHALL occur on an edge with Enable=1 and start=1, capturing u into the accumulator.
REQ-020 FB1 SHALL add a1*w1; FB2 SHALL add a2*w2 and latch the saturated accumulator as w.
REQ-021 FF0, FF1, FF2 SHALL accumulate b0*w, b1*w1, b2*w2 from zero.
REQ-022 On leaving FF2, y, w1 and w2 SHALL update together; done SHALL be 1 in the following cycle only.
REQ-023 Latency: start in cycle 0 -> busy 1 in cycles 1-5 -> done 1 and new y in cycle 6; start accepted again in cycle 6.
REQ-024 Each product SHALL be the full 2W-bit product, arithmetically shifted right by FRAC (truncation toward minus infinity).
REQ-025 Every accumulation SHALL saturate to [-2^(W-1), 2^(W-1)-1]; no wrap-around.
REQ-026 start while busy SHALL be ignored and SHALL pulse overrun for one cycle; the computation in progress SHALL be unaffected.
REQ-027 coef_we in IDLE SHALL write coef_data to the indexed coefficient; writes while busy or to indices 5-7 SHALL be dropped.
REQ-028 If coef_we and start coincide in IDLE, the write SHALL take effect and the new sample SHALL use the new coefficient.
REQ-029 clr_hist in IDLE SHALL zero w1 and w2; it SHALL be ignored while busy; clr_hist with start SHALL clear first, then compute with zero history.
REQ-030 Enable=0 SHALL freeze the FSM, accumulator, history, y and coefficients; done and overrun SHALL be 0 while Enable=0.

Reset
REQ-031 Reset=1 SHALL immediately force state IDLE, busy 0, done 0, overrun 0, y 0, w1 0, w2 0 and accumulator 0.
REQ-032 Reset SHALL set coefficients to b0=2^FRAC and b1=b2=a1=a2=0, giving pass-through.
REQ-033 Reset asserted mid-computation SHALL abandon the sample with no done pulse.

Structure
REQ-034 A shared package filtro_pkg SHALL hold W, FRAC, the FSM state type, coefficient index constants and the saturation limits.
REQ-035 The shared multiply/shift/saturate SHALL be one sub-module, mult_q, instantiated once.

Verification
REQ-036 Test after reset with u=1000 and start in cycle 0 -> done in cycle 6, y=1000, busy 1 in cycles 1-5.
REQ-037 Test with b0=8192, a1=8192 and inputs 100, 0, 0 -> y=100, 100, 100; clr_hist, then input 0 -> y=0.
REQ-038 Test with b0=8192, a1=8192 and input 16777215 twice -> second y=16777215 (saturated, not negative).
REQ-039 Test with start in cycle 0 (u=50) and in cycle 2 (u=70) -> overrun pulse in cycle 3, single done in cycle 6 with y=50.
REQ-040 Test with Reset asserted in cycle 3 of a computation -> y=0, busy=0, no done; after release, start u=5 -> y=5.
REQ-041 Test with coef_we (addr 0, data 4096) while busy -> dropped, y=u; the same write in IDLE -> next y=u/2.
